gfx_mem_arbiter: RTL and testbench

Two-port memory arbiter that sits between the graphics engines and the single-port frame-buffer SRAM. It is the responder end of the engine request interface (rts/rtr/wben/addr/data/op, returned data/xfc). It accepts write and read requests from two requesters, serialises them onto the SRAM and returns read data to the issuing port. Port 0 is the fill-rect data generator; port 1 is the readback/display engine.

---
 rtl/gfx_pkg.sv | 12 +
 rtl/gfx_arb_select.sv | 64 ++++++
 rtl/gfx_mem_arbiter.sv | 95 +++++++++
 tb/tb_gfx_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types and widths for the graphics memory path.
package gfx_pkg;
  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int WBEN_W       = 4;
  localparam int FB_ROW_WORDS = 240;

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;
endpackage

// File: rtl/gfx_arb_select.sv
// Grant selection for the two engine ports. ARB_RR_EN selects round-robin with
// burst fairness; without it port 0 has strict priority and no state is kept.
module gfx_arb_select
  import gfx_pkg::*;
`ifdef ARB_RR_EN
  #(parameter int MAX_BURST = 16)
`endif
(
`ifdef ARB_RR_EN
  input  logic clk,
`endif
  input  logic rst_,
  input  logic arb_en,
  input  logic p0_rts,
  input  logic p1_rts,
  output logic p0_gnt,
  output logic p1_gnt
);

  logic active;
  assign active = rst_ & arb_en;

`ifdef ARB_RR_EN
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  port_t      last_owner;
  port_t      gnt_port;
  logic [7:0] burst_cnt;
  logic       keep;

  // A zero count means nobody holds a burst, so the reset owner (port 1) yields the first tie.
  assign keep     = (burst_cnt != 8'd0) && (burst_cnt < BURST_LIM);
  assign gnt_port = p1_gnt ? PORT1 : PORT0;

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (active) begin
      if (p0_rts && p1_rts) begin
        if ((last_owner == PORT0) == keep) p0_gnt = 1'b1;
        else                               p1_gnt = 1'b1;
      end else begin
        p0_gnt = p0_rts;
        p1_gnt = p1_rts;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      last_owner <= PORT1;
      burst_cnt  <= 8'd0;
    end else if (p0_gnt || p1_gnt) begin
      last_owner <= gnt_port;
      if (gnt_port != last_owner)    burst_cnt <= 8'd1;
      else if (burst_cnt < BURST_LIM) burst_cnt <= burst_cnt + 8'd1;
    end
  end
`else
  assign p0_gnt = active & p0_rts;
  assign p1_gnt = active & p1_rts & ~p0_rts;
`endif

endmodule

// File: rtl/gfx_mem_arbiter.sv
// Two-port frame-buffer SRAM arbiter: memory mux plus read-return pipeline.
// Build with ARB_RR_EN for round-robin/MAX_BURST fairness, else strict port-0 priority.
module gfx_mem_arbiter
  import gfx_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              p0_rts,
  output logic              p0_rtr,
  input  logic [WBEN_W-1:0] p0_wben,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p0_op,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_xfc,
  input  logic              p1_rts,
  output logic              p1_rtr,
  input  logic [WBEN_W-1:0] p1_wben,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p1_op,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_xfc,
  output logic              mem_ce,
  output logic [WBEN_W-1:0] mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Unsupported parameter values leave the arbiter permanently idle.
  localparam logic PARAM_OK = (MEM_RD_LAT == 1) && (MAX_BURST >= 1) && (MAX_BURST <= 255);

  logic p0_gnt, p1_gnt;
  logic rd_pend0, rd_pend1;

  gfx_arb_select
`ifdef ARB_RR_EN
    #(.MAX_BURST(MAX_BURST))
`endif
  u_select (
`ifdef ARB_RR_EN
    .clk    (clk),
`endif
    .rst_   (rst_),
    .arb_en (PARAM_OK),
    .p0_rts (p0_rts),
    .p1_rts (p1_rts),
    .p0_gnt (p0_gnt),
    .p1_gnt (p1_gnt)
  );

  assign p0_rtr = p0_gnt;
  assign p1_rtr = p1_gnt;

  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_ce    = 1'b1;
      mem_addr  = p0_addr;
      mem_wdata = p0_data;
      mem_we    = (p0_op == OP_READ) ? '0 : p0_wben;
    end else if (p1_gnt) begin
      mem_ce    = 1'b1;
      mem_addr  = p1_addr;
      mem_wdata = p1_data;
      mem_we    = (p1_op == OP_READ) ? '0 : p1_wben;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
      p0_xfc   <= 1'b0;
      p1_xfc   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      rd_pend0 <= p0_gnt && (p0_op == OP_READ);
      rd_pend1 <= p1_gnt && (p1_op == OP_READ);
      p0_xfc   <= rd_pend0;
      p1_xfc   <= rd_pend1;
      if (rd_pend0) p0_rdata <= mem_rdata;
      if (rd_pend1) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Bench for gfx_mem_arbiter: directed table, corner sequences and random traffic vs a reference model.
module tb_gfx_mem_arbiter;
  import gfx_pkg::*;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_;
  logic        p0_rts, p0_op, p1_rts, p1_op;
  logic [3:0]  p0_wben, p1_wben;
  logic [15:0] p0_addr, p1_addr;
  logic [31:0] p0_data, p1_data;
  logic        p0_rtr, p1_rtr, p0_xfc, p1_xfc;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_ce;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  gfx_mem_arbiter #(.MAX_BURST(BURST), .MEM_RD_LAT(1)) dut (
    .clk(clk), .rst_(rst_),
    .p0_rts(p0_rts), .p0_rtr(p0_rtr), .p0_wben(p0_wben), .p0_addr(p0_addr),
    .p0_data(p0_data), .p0_op(p0_op), .p0_rdata(p0_rdata), .p0_xfc(p0_xfc),
    .p1_rts(p1_rts), .p1_rtr(p1_rtr), .p1_wben(p1_wben), .p1_addr(p1_addr),
    .p1_data(p1_data), .p1_op(p1_op), .p1_rdata(p1_rdata), .p1_xfc(p1_xfc),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM environment: one-cycle registered read, byte-lane writes.
  logic [31:0] sram [0:65535];
  always @(posedge clk) begin
    if (mem_ce) begin
      mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model state
  typedef struct { logic [31:0] d; int due; } ret_t;
  ret_t        q0[$], q1[$];
  logic [31:0] ref_mem [0:65535];
  logic [31:0] last0, last1;
  int          owner, run;
  int          cyc, total, bad;

  typedef struct {
    logic r0, o0; logic [15:0] a0; logic [31:0] d0; logic [3:0] w0;
    logic r1, o1; logic [15:0] a1;
    logic e_rtr0, e_rtr1; logic [3:0] e_we;
    logic e_x0; logic [31:0] e_rd0; logic e_x1; logic [31:0] e_rd1;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_idle();
    p0_rts = 1'b0; p0_op = OP_WRITE; p0_addr = '0; p0_data = '0; p0_wben = '0;
    p1_rts = 1'b0; p1_op = OP_WRITE; p1_addr = '0; p1_data = '0; p1_wben = '0;
  endtask

  task automatic set_p0(input logic op, input logic [15:0] a, input logic [31:0] d, input logic [3:0] w);
    p0_rts = 1'b1; p0_op = op; p0_addr = a; p0_data = d; p0_wben = w;
  endtask

  task automatic set_p1(input logic op, input logic [15:0] a, input logic [31:0] d, input logic [3:0] w);
    p1_rts = 1'b1; p1_op = op; p1_addr = a; p1_data = d; p1_wben = w;
  endtask

  // Compare every DUT output for the current cycle against the model, then advance the model.
  task automatic neg_check();
    logic e0, e1, ex, op;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0] w;
    int p;
    @(negedge clk);
    if (!rst_) begin
      chk("rst_rtr0", p0_rtr, 0);   chk("rst_rtr1", p1_rtr, 0);
      chk("rst_xfc0", p0_xfc, 0);   chk("rst_xfc1", p1_xfc, 0);
      chk("rst_rdata0", p0_rdata, 0); chk("rst_rdata1", p1_rdata, 0);
      chk("rst_ce", mem_ce, 0);     chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0; owner = 1; run = 0;
    end else begin
      e0 = 1'b0; e1 = 1'b0;
      if (p0_rts && p1_rts) begin
`ifdef ARB_RR_EN
        if (run > 0 && run < BURST) begin e0 = (owner == 0); e1 = (owner == 1); end
        else                        begin e0 = (owner == 1); e1 = (owner == 0); end
`else
        e0 = 1'b1;
`endif
      end else begin
        e0 = p0_rts; e1 = p1_rts;
      end
      chk("rtr0", p0_rtr, e0);
      chk("rtr1", p1_rtr, e1);

      ex = (q0.size() > 0) && (q0[0].due == cyc);
      chk("xfc0", p0_xfc, ex);
      if (ex) begin last0 = q0[0].d; void'(q0.pop_front()); end
      chk("rdata0", p0_rdata, last0);
      ex = (q1.size() > 0) && (q1[0].due == cyc);
      chk("xfc1", p1_xfc, ex);
      if (ex) begin last1 = q1[0].d; void'(q1.pop_front()); end
      chk("rdata1", p1_rdata, last1);

      if (e0 || e1) begin
        p  = e0 ? 0 : 1;
        op = e0 ? p0_op : p1_op;
        a  = e0 ? p0_addr : p1_addr;
        d  = e0 ? p0_data : p1_data;
        w  = e0 ? p0_wben : p1_wben;
        chk("mem_ce", mem_ce, 1);
        chk("mem_addr", mem_addr, a);
        chk("mem_we", mem_we, (op == OP_READ) ? 4'h0 : w);
        chk("mem_wdata", mem_wdata, d);
        if (op == OP_READ) begin
          if (p == 0) q0.push_back('{d: ref_mem[a], due: cyc + 2});
          else        q1.push_back('{d: ref_mem[a], due: cyc + 2});
        end else begin
          for (int b = 0; b < 4; b++)
            if (w[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        run   = (p == owner) ? ((run < BURST) ? run + 1 : run) : 1;
        owner = p;
      end else begin
        chk("mem_ce_idle", mem_ce, 0);
        chk("mem_we_idle", mem_we, 0);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic step();
    neg_check();
    advance();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    owner = 1; run = 0; last0 = '0; last1 = '0;
    for (int i = 0; i < 65536; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    mem_rdata = '0;

    //           r0    o0        a0        d0            w0       r1    o1       a1        rtr0  rtr1  we       x0    rd0           x1    rd1
    tbl[0] = '{1'b1, OP_WRITE, 16'h0010, 32'hA5A5A5A5, 4'b0101, 1'b0, OP_WRITE, 16'h0000, 1'b1, 1'b0, 4'b0101, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1] = '{1'b0, OP_WRITE, 16'h0000, 32'h0,        4'b0000, 1'b1, OP_READ,  16'h0010, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[2] = '{1'b0, OP_WRITE, 16'h0000, 32'h0,        4'b0000, 1'b0, OP_WRITE, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[3] = '{1'b0, OP_WRITE, 16'h0000, 32'h0,        4'b0000, 1'b0, OP_WRITE, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b1, 32'h00A500A5};
    tbl[4] = '{1'b1, OP_WRITE, 16'h00EF, 32'h12345678, 4'b1111, 1'b0, OP_WRITE, 16'h0000, 1'b1, 1'b0, 4'b1111, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[5] = '{1'b1, OP_READ,  16'h00EF, 32'h0,        4'b0000, 1'b0, OP_WRITE, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[6] = '{1'b1, OP_WRITE, 16'h00EF, 32'hCAFEF00D, 4'b1111, 1'b0, OP_WRITE, 16'h0000, 1'b1, 1'b0, 4'b1111, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[7] = '{1'b1, OP_READ,  16'h00EF, 32'h0,        4'b0000, 1'b0, OP_WRITE, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h12345678, 1'b0, 32'h0};
    tbl[8] = '{1'b0, OP_WRITE, 16'h0000, 32'h0,        4'b0000, 1'b0, OP_WRITE, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[9] = '{1'b0, OP_WRITE, 16'h0000, 32'h0,        4'b0000, 1'b0, OP_WRITE, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0};

    // Reset with both ports requesting: rtr must stay low.
    rst_ = 1'b0;
    set_idle();
    p0_rts = 1'b1; p1_rts = 1'b1;
    step(); step();
    set_idle();
    rst_ = 1'b1;
    step();

    // Directed table: byte-lane write/readback and same-address ordering.
    for (int i = 0; i < 10; i++) begin
      p0_rts = tbl[i].r0; p0_op = tbl[i].o0; p0_addr = tbl[i].a0; p0_data = tbl[i].d0; p0_wben = tbl[i].w0;
      p1_rts = tbl[i].r1; p1_op = tbl[i].o1; p1_addr = tbl[i].a1; p1_data = '0; p1_wben = '0;
      neg_check();
      chk("tbl_rtr0", p0_rtr, tbl[i].e_rtr0);
      chk("tbl_rtr1", p1_rtr, tbl[i].e_rtr1);
      chk("tbl_we", mem_we, tbl[i].e_we);
      chk("tbl_xfc0", p0_xfc, tbl[i].e_x0);
      chk("tbl_xfc1", p1_xfc, tbl[i].e_x1);
      if (tbl[i].e_x0) chk("tbl_rdata0", p0_rdata, tbl[i].e_rd0);
      if (tbl[i].e_x1) chk("tbl_rdata1", p1_rdata, tbl[i].e_rd1);
      advance();
    end

    // Preload addrs 0..7, then alternate p0/p1 reads every cycle.
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_p0(OP_WRITE, 16'(i), 32'h1000_0000 + 32'(i) * 32'h0111_0111, 4'hF);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      set_idle();
      if (i % 2 == 0) set_p0(OP_READ, 16'(i), 32'h0, 4'h0);
      else            set_p1(OP_READ, 16'(i), 32'h0, 4'h0);
      step();
    end
    set_idle();
    repeat (3) step();

    // Read accepted, then reset in the following cycle: the return is dropped.
    set_p0(OP_READ, 16'h0003, 32'h0, 4'h0);
    step();
    rst_ = 1'b0;
    neg_check();
    chk("midrst_rtr0", p0_rtr, 0);
    advance();
    step();
    rst_ = 1'b1;
    set_p0(OP_READ, 16'h0003, 32'h0, 4'h0);
    step();
    set_idle();
    neg_check();
    chk("postrst_xfc0_early", p0_xfc, 0);
    advance();
    neg_check();
    chk("postrst_xfc0", p0_xfc, 1);
    chk("postrst_rdata0", p0_rdata, 32'h1000_0000 + 32'd3 * 32'h0111_0111);
    advance();

    // Both ports stream writes from a clean reset.
    rst_ = 1'b0;
    step();
    rst_ = 1'b1;
`ifdef ARB_RR_EN
    for (int i = 0; i < 12; i++) begin
      set_p0(OP_WRITE, 16'(FB_ROW_WORDS + i), $urandom, 4'hF);
      set_p1(OP_WRITE, 16'(2 * FB_ROW_WORDS + i), $urandom, 4'hF);
      neg_check();
      chk("burst_rtr0", p0_rtr, ((i / 4) % 2) == 0);
      chk("burst_rtr1", p1_rtr, ((i / 4) % 2) == 1);
      advance();
    end
`else
    for (int i = 0; i < 100; i++) begin
      set_p0(OP_WRITE, 16'(FB_ROW_WORDS + i), $urandom, 4'hF);
      set_p1(OP_WRITE, 16'(2 * FB_ROW_WORDS + i), $urandom, 4'hF);
      neg_check();
      chk("starve_rtr1", p1_rtr, 0);
      advance();
    end
`endif

    // Random mixed traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      set_idle();
      if ($urandom_range(3) != 0)
        set_p0(logic'($urandom_range(1)), 16'($urandom_range(15)), $urandom, 4'($urandom_range(15)));
      if ($urandom_range(3) != 0)
        set_p1(logic'($urandom_range(1)), 16'($urandom_range(15)), $urandom, 4'($urandom_range(15)));
      step();
    end
    set_idle();
    repeat (4) step();
    chk("drain", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
